// File: rtl/spi_host_master.sv
// spi_host_master: byte-wide SPI master driving an io-controller SPI link in
// mode 0, MSB first. There are four software-controlled chip selects, and each
// one is active low on the pins. One byte shifts every 16*CLKDIV clk cycles.
// Defining SPI_HOST_BURST_EN adds a one-entry holding register so that bytes
// can chain with no idle cycle between them.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transfer; sck low, mosi low, ready for a byte
// LOW     | sck low for CLKDIV cycles; mosi holds the current bit
// HIGH    | sck high for CLKDIV cycles; miso was sampled on entry
module spi_host_master #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_we,
  input  logic [3:0] cs_value,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_conf_data0_n,
  output logic       spi_ss2_n,
  output logic       spi_ss3_n,
  output logic       spi_ss4_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);

  logic [1:0] state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] tx_shift;   // bits still to be sent after the one on mosi
  logic [7:0] rx_shift;
  logic [3:0] sel_n;
  logic       accept;
  logic       phase_end;
  logic       byte_done;

  assign busy      = (state != ST_IDLE);
  assign phase_end = (div_cnt == 8'd0);
  assign byte_done = (state == ST_HIGH) && phase_end && (bit_cnt == 3'd7);
  assign accept    = tx_valid && tx_ready;

  assign {spi_ss4_n, spi_ss3_n, spi_ss2_n, spi_conf_data0_n} = sel_n;

`ifdef SPI_HOST_BURST_EN
  logic [7:0] hold_data;
  logic       hold_full;
  logic       chain_go;
  logic [7:0] chain_byte;

  assign tx_ready   = !hold_full;
  // At the end of a byte, a held byte wins. Otherwise a byte offered on that
  // same edge goes straight into the shifter.
  assign chain_go   = hold_full || tx_valid;
  assign chain_byte = hold_full ? hold_data : tx_data;

  // Holding register: fills while a transfer is running and empties when the byte ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (byte_done) begin
      hold_full <= 1'b0;
    end else if (accept && busy) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end
  end
`else
  assign tx_ready = (state == ST_IDLE);
`endif

  // Chip-select register: selects can only be changed between transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_n <= 4'hF;
    end else if (cs_we && !busy) begin
      sel_n <= ~cs_value;
    end
  end

  // Shift engine: half-period down-counter plus the IDLE/LOW/HIGH sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      div_cnt  <= DIV_LOAD;
      bit_cnt  <= 3'd0;
      tx_shift <= 7'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_shift <= tx_data[6:0];
            spi_mosi <= tx_data[7];
            bit_cnt  <= 3'd0;
            div_cnt  <= DIV_LOAD;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            spi_sck  <= 1'b1;
            rx_shift <= {rx_shift[6:0], spi_miso};
            div_cnt  <= DIV_LOAD;
            state    <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            spi_sck <= 1'b0;
            div_cnt <= DIV_LOAD;
            if (bit_cnt != 3'd7) begin
              spi_mosi <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= ST_LOW;
            end else begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
`ifdef SPI_HOST_BURST_EN
              if (chain_go) begin
                tx_shift <= chain_byte[6:0];
                spi_mosi <= chain_byte[7];
                bit_cnt  <= 3'd0;
                state    <= ST_LOW;
              end else begin
                spi_mosi <= 1'b0;
                state    <= ST_IDLE;
              end
`else
              spi_mosi <= 1'b0;
              state    <= ST_IDLE;
`endif
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: two DUTs are instantiated, one with CLKDIV=4 and one
// with CLKDIV=1. A slave model drives miso bit by bit. Waveform properties
// (phase lengths, bit order, rx_valid timing) are derived from the byte-level
// rules and compared against the DUT pins.
module tb_spi_host_master;

`ifdef SPI_HOST_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk;
  logic       reset    [2];
  logic       cs_we    [2];
  logic [3:0] cs_value [2];
  logic       tx_valid [2];
  logic [7:0] tx_data  [2];
  logic       tx_ready [2];
  logic       rx_valid [2];
  logic [7:0] rx_data  [2];
  logic       busy     [2];
  logic       sck      [2];
  logic       mosi     [2];
  logic       miso     [2];
  logic       conf_n   [2];
  logic       ss2_n    [2];
  logic       ss3_n    [2];
  logic       ss4_n    [2];

  logic [3:0] cs_model [2];
  int n_pass  = 0;
  int n_total = 0;

  spi_host_master #(.CLKDIV(4)) u_div4 (
    .clk(clk), .reset(reset[0]), .cs_we(cs_we[0]), .cs_value(cs_value[0]),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
    .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .busy(busy[0]),
    .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
    .spi_conf_data0_n(conf_n[0]), .spi_ss2_n(ss2_n[0]),
    .spi_ss3_n(ss3_n[0]), .spi_ss4_n(ss4_n[0])
  );

  spi_host_master #(.CLKDIV(1)) u_div1 (
    .clk(clk), .reset(reset[1]), .cs_we(cs_we[1]), .cs_value(cs_value[1]),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
    .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .busy(busy[1]),
    .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
    .spi_conf_data0_n(conf_n[1]), .spi_ss2_n(ss2_n[1]),
    .spi_ss3_n(ss3_n[1]), .spi_ss4_n(ss4_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] sels(input int d);
    return {ss4_n[d], ss3_n[d], ss2_n[d], conf_n[d]};
  endfunction

  function automatic logic [16:0] out_vec(input int d);
    return {sck[d], mosi[d], sels(d), tx_ready[d], rx_valid[d], rx_data[d], busy[d]};
  endfunction

  localparam logic [16:0] RESET_VEC = {1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0};

  task automatic test_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (out_vec(d) !== RESET_VEC)
        $display("FAIL reset_state d%0d: got %h want %h", d, out_vec(d), RESET_VEC);
      else n_pass++;
    end
  endtask

  task automatic test_cs();
    @(negedge clk);
    cs_we[0] = 1'b1; cs_value[0] = 4'b0001; cs_model[0] = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    cs_we[0] = 1'b0;
    n_total++;
    if (sels(0) !== 4'b1110) $display("FAIL cs_write: got %b want %b", sels(0), 4'b1110);
    else n_pass++;
  endtask

  // Sends one byte on DUT d. It must be called at a negedge, and it returns at
  // the negedge where rx_valid is seen. acc_t is the time of the acceptance edge.
  task automatic xfer(input int d, input logic [7:0] tx, input logic [7:0] slv,
                      input bit do_cs, input logic [3:0] csv,
                      output longint acc_t, output int rx_c);
    int div, rises, low_run, high_run;
    logic prev_s, prev_m, s;
    logic [7:0] got;
    bit done;
    div = div_of(d); rises = 0; low_run = 0; high_run = 0; got = 8'h00; done = 1'b0;
    n_total++;
    if (tx_ready[d] !== 1'b1) $display("FAIL ready_before d%0d: got %b want 1", d, tx_ready[d]);
    else n_pass++;
    tx_valid[d] = 1'b1; tx_data[d] = tx;
    if (do_cs) begin cs_we[d] = 1'b1; cs_value[d] = csv; cs_model[d] = csv; end
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    tx_valid[d] = 1'b0; cs_we[d] = 1'b0; tx_data[d] = 8'($urandom);
    prev_s = 1'b0; prev_m = mosi[d]; rx_c = -1;
    for (int c = 1; c <= 16 * div + 4 && !done; c++) begin
      if (c > 1) @(negedge clk);
      s = sck[d];
      if (c == 1) begin
        n_total++;
        if ({mosi[d], busy[d], tx_ready[d], sels(d)} !== {tx[7], 1'b1, BURST, ~cs_model[d]})
          $display("FAIL first_cycle d%0d: got mosi/busy/rdy/sel %b want %b", d,
                   {mosi[d], busy[d], tx_ready[d], sels(d)}, {tx[7], 1'b1, BURST, ~cs_model[d]});
        else n_pass++;
      end
      if (s && !prev_s) begin
        n_total++;
        if (low_run !== div || mosi[d] !== prev_m)
          $display("FAIL low_phase d%0d bit%0d: got low_run %0d mosi %b want %0d mosi %b",
                   d, rises, low_run, mosi[d], div, prev_m);
        else n_pass++;
        if (rises < 8) got[7 - rises] = mosi[d];
        rises++; low_run = 0; high_run = 0;
      end else if (!s && prev_s) begin
        n_total++;
        if (high_run !== div) $display("FAIL high_phase d%0d: got %0d want %0d", d, high_run, div);
        else n_pass++;
        high_run = 0; low_run = 0;
      end
      if (s) high_run++; else low_run++;
      if (rx_valid[d]) begin
        rx_c = c; done = 1'b1;
        n_total++;
        if (c !== 16 * div + 1) $display("FAIL rx_time d%0d: got %0d want %0d", d, c, 16 * div + 1);
        else n_pass++;
        n_total++;
        if (rx_data[d] !== slv) $display("FAIL rx_data d%0d: got %h want %h", d, rx_data[d], slv);
        else n_pass++;
        n_total++;
        if (got !== tx || rises !== 8)
          $display("FAIL mosi_bits d%0d: got %h (%0d rises) want %h (8 rises)", d, got, rises, tx);
        else n_pass++;
        n_total++;
        if (sels(d) !== ~cs_model[d] || s !== 1'b0)
          $display("FAIL end_state d%0d: got sel %b sck %b want sel %b sck 0", d, sels(d), s, ~cs_model[d]);
        else n_pass++;
      end else if (!s && rises < 8) begin
        miso[d] = slv[7 - rises];
      end
      prev_s = s; prev_m = mosi[d];
    end
    if (!done) begin
      n_total++;
      $display("FAIL rx_timeout d%0d: got no rx_valid want one at cycle %0d", d, 16 * div + 1);
    end
  endtask

  task automatic test_basic();
    longint t; int r;
    xfer(0, 8'hA5, 8'h3C, 1'b0, 4'h0, t, r);
    @(negedge clk);
    n_total++;
    if (rx_valid[0] !== 1'b0 || rx_data[0] !== 8'h3C)
      $display("FAIL rx_pulse_width: got valid %b data %h want 0 3c", rx_valid[0], rx_data[0]);
    else n_pass++;
  endtask

  task automatic test_cs_with_accept();
    longint t; int r;
    xfer(0, 8'($urandom), 8'($urandom), 1'b1, 4'b0100, t, r);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    longint t1, t2; int r;
    xfer(1, 8'hFF, 8'($urandom), 1'b0, 4'h0, t1, r);
    xfer(1, 8'h00, 8'($urandom), 1'b0, 4'h0, t2, r);
    n_total++;
    if (t2 - t1 !== 64'd170) $display("FAIL b2b_gap: got %0d ns want 170 ns", t2 - t1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    longint t; int r, d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 1);
      xfer(d, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), t, r);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_midbyte();
    int pulses;
    pulses = 0;
    tx_valid[0] = 1'b1; tx_data[0] = 8'($urandom);
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
      if (c == 10) begin cs_we[0] = 1'b1; cs_value[0] = 4'b0010; end
      if (c == 11) begin
        cs_we[0] = 1'b0;
        n_total++;
        if (sels(0) !== ~cs_model[0]) $display("FAIL cs_ignored_busy: got %b want %b", sels(0), ~cs_model[0]);
        else n_pass++;
      end
    end
    reset[0] = 1'b1;
    cs_model[0] = 4'h0;
    #1;
    n_total++;
    if (out_vec(0) !== RESET_VEC) $display("FAIL reset_midbyte: got %h want %h", out_vec(0), RESET_VEC);
    else n_pass++;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (rx_valid[0]) pulses++;
      if (c == 2) reset[0] = 1'b0;
    end
    n_total++;
    if (pulses !== 0 || out_vec(0) !== RESET_VEC)
      $display("FAIL no_rx_after_reset: got %0d pulses state %h want 0 pulses %h", pulses, out_vec(0), RESET_VEC);
    else n_pass++;
  endtask

`ifdef SPI_HOST_BURST_EN
  task automatic test_burst();
    logic [7:0] txb [3];
    logic [7:0] slb [3];
    logic [7:0] got [3];
    logic [7:0] rxd [3];
    int rxc [3];
    int sent, rises, nrx, low_run;
    logic prev_s, s;
    sent = 1; rises = 0; nrx = 0; low_run = 0; prev_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      txb[i] = 8'($urandom); slb[i] = 8'($urandom); got[i] = 8'h00; rxd[i] = 8'h00; rxc[i] = 0;
    end
    tx_valid[0] = 1'b1; tx_data[0] = txb[0];
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
      if (sent < 3 && tx_ready[0]) begin tx_valid[0] = 1'b1; tx_data[0] = txb[sent]; sent++; end
      s = sck[0];
      if (s && !prev_s) begin
        n_total++;
        if (low_run !== 4) $display("FAIL burst_low d0 edge%0d: got %0d want 4", rises, low_run);
        else n_pass++;
        if (rises < 24) got[rises / 8][7 - (rises % 8)] = mosi[0];
        rises++; low_run = 0;
      end else if (!s && prev_s) begin
        low_run = 0;
      end
      if (!s) low_run++;
      if (rx_valid[0]) begin
        if (nrx < 3) begin rxc[nrx] = c; rxd[nrx] = rx_data[0]; end
        nrx++;
      end
      if (!s && rises < 24) miso[0] = slb[rises / 8][7 - (rises % 8)];
      prev_s = s;
    end
    n_total++;
    if (rises !== 24 || nrx !== 3) $display("FAIL burst_count: got %0d rises %0d rx want 24 3", rises, nrx);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (rxc[i] !== 64 * (i + 1) + 1 || rxd[i] !== slb[i] || got[i] !== txb[i])
        $display("FAIL burst_byte%0d: got cyc %0d rx %h tx %h want %0d %h %h",
                 i, rxc[i], rxd[i], got[i], 64 * (i + 1) + 1, slb[i], txb[i]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; cs_we[d] = 1'b0; cs_value[d] = 4'h0; tx_valid[d] = 1'b0;
      tx_data[d] = 8'h00; miso[d] = 1'b0; cs_model[d] = 4'h0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0; reset[1] = 1'b0;
    test_reset();
    test_cs();
    test_basic();
    test_cs_with_accept();
    test_back_to_back();
    test_random();
    test_midbyte();
`ifdef SPI_HOST_BURST_EN
    test_burst();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
